// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// request combine modes and the manual-reset counter limit.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    localparam int MODE_CHORD = 0;
    localparam int MODE_ANY   = 1;

    localparam logic [7:0] COUNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request and status bundle between the board wrapper (master) and the
// reset sequencer (slave).
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int NUM_REQ     = 3
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   busy;
    logic                   done;
    logic                   last_cause;
    logic [7:0]             reset_count;
    logic                   tick;

    modport master (
        output req,
        input  rst_out, busy, done, last_cause, reset_count, tick
    );

    modport slave (
        input  req,
        output rst_out, busy, done, last_cause, reset_count, tick
    );
endinterface

// File: rtl/reset_sequencer_req_debounce.sv
// Synchronises the raw manual request buttons, combines them (chord or any)
// and debounces the result into a single clean req_db level.
module req_debounce
    import rst_seq_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int REQ_MODE        = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic               req_db
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NUM_REQ-1:0] sync_bits;
    logic               combined;
    logic               db_q, db_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[0], req[gi]};
            end
            assign sync_bits[gi] = sync_q[1];
        end
    endgenerate

    assign combined = (REQ_MODE == MODE_CHORD) ? (&sync_bits) :
                      (REQ_MODE == MODE_ANY)   ? (|sync_bits) : 1'b0;

    // The count only advances while the combined level disagrees with the
    // debounced one; any agreeing cycle starts the run over.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (combined != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
            else                                       cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_db = db_q;
endmodule

// File: rtl/reset_sequencer.sv
// Power-on / manual reset sequencer: holds every domain in reset, then
// releases them one at a time; also counts manual resets and emits a tick.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int NUM_REQ         = 3,
    parameter int REQ_MODE        = 0,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int STAGE_GAP       = 4,
    parameter int TICK_DIV        = 50
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
    localparam int STG_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);

    seq_state_e             state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [STG_W-1:0]       stage_q, stage_d, stage_inc;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   cause_q, cause_d;
    logic [7:0]             count_q, count_d;
    logic                   req_db, req_db_prev_q, db_rise;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                   tick_q, tick_d;

    req_debounce #(
        .NUM_REQ         (NUM_REQ),
        .REQ_MODE        (REQ_MODE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_req_debounce (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req),
        .req_db (req_db)
    );

    assign db_rise   = req_db & ~req_db_prev_q;
    assign stage_inc = stage_q + STG_W'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            ST_HOLD: begin
                if (req_db) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    gap_d   = '0;
                    stage_d = '0;
                    state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
                    gap_d   = '0;
                    stage_d = stage_inc;
                    if (stage_inc == STG_W'(NUM_DOMAINS - 1)) state_d = ST_RUN;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: ;
        endcase

        // A fresh button press outside HOLD restarts the whole schedule and
        // takes priority over any release step due on the same edge.
        if (db_rise && state_q != ST_HOLD) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            gap_d   = '0;
            stage_d = '0;
            cause_d = 1'b1;
            count_d = sat_inc(count_q);
        end

        busy_d    = (state_d != ST_RUN);
        done_d    = (state_d == ST_RUN);
        rst_out_d = '1;
        if (state_d == ST_RUN) begin
            rst_out_d = '0;
        end else if (state_d == ST_RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) rst_out_d[i] = (STG_W'(i) > stage_d);
        end

        tick_cnt_d = (tick_cnt_q == TICK_W'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TICK_W'(1);
        tick_d     = (tick_cnt_d == TICK_W'(TICK_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            hold_q        <= '0;
            gap_q         <= '0;
            stage_q       <= '0;
            rst_out_q     <= '1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            cause_q       <= 1'b0;
            count_q       <= '0;
            req_db_prev_q <= 1'b0;
            tick_cnt_q    <= '0;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            gap_q         <= gap_d;
            stage_q       <= stage_d;
            rst_out_q     <= rst_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cause_q       <= cause_d;
            count_q       <= count_d;
            req_db_prev_q <= req_db;
            tick_cnt_q    <= tick_cnt_d;
            tick_q        <= tick_d;
        end
    end

    assign bus.rst_out     = rst_out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.last_cause  = cause_q;
    assign bus.reset_count = count_q;
    assign bus.tick        = tick_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Two sequencers (chord mode with long debounce, any mode with short debounce)
// checked every cycle against a timeline model, plus directed literal checks.
module tb_reset_sequencer;
    localparam int ND = 4, NR = 3, HOLD = 8, GAP = 4, TDIV = 50;
    localparam int DB0 = 16, DB1 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_DOMAINS(ND), .NUM_REQ(NR)) sif0 ();
    reset_sequencer_if #(.NUM_DOMAINS(ND), .NUM_REQ(NR)) sif1 ();

    reset_sequencer #(
        .NUM_DOMAINS(ND), .NUM_REQ(NR), .REQ_MODE(0), .DEBOUNCE_CYCLES(DB0),
        .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .TICK_DIV(TDIV)
    ) dut0 (.clk(clk), .reset(reset), .bus(sif0));

    reset_sequencer #(
        .NUM_DOMAINS(ND), .NUM_REQ(NR), .REQ_MODE(1), .DEBOUNCE_CYCLES(DB1),
        .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .TICK_DIV(TDIV)
    ) dut1 (.clk(clk), .reset(reset), .bus(sif1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: t0 is the first cycle of the current hold countdown;
    // domain i is out of reset from cycle t0 + HOLD + i*GAP onwards.
    bit model_valid = 1'b0;
    int cyc = 0;
    int m_t0[2], m_cnt[2];
    bit m_cause[2], m_db[2], m_db_prev[2];
    bit hist[2][64];

    function automatic bit comb_of(input int m);
        return (m == 0) ? (&sif0.req) : (|sif1.req);
    endfunction

    task automatic model_step();
        bit flip, s, rise, in_hold;
        int dbn;
        for (int m = 0; m < 2; m++) begin
            dbn = (m == 0) ? DB0 : DB1;
            hist[m][cyc % 64] = comb_of(m);
            // Debounced level flips once the last dbn synchronised samples all disagree.
            flip = 1'b1;
            for (int j = cyc - dbn + 1; j <= cyc; j++) begin
                s = (j < 2) ? 1'b0 : hist[m][(j - 2) % 64];
                if (j < 0 || s == m_db[m]) flip = 1'b0;
            end
            rise    = m_db[m] && !m_db_prev[m];
            in_hold = cyc < m_t0[m] + HOLD;
            if (in_hold && m_db[m]) begin
                m_t0[m] = cyc + 1;
            end else if (!in_hold && rise) begin
                m_t0[m]    = cyc + 1;
                m_cnt[m]   = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
                m_cause[m] = 1'b1;
            end
            m_db_prev[m] = m_db[m];
            if (flip) m_db[m] = !m_db[m];
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            cyc = 0;
            for (int m = 0; m < 2; m++) begin
                m_t0[m] = 0; m_cnt[m] = 0; m_cause[m] = 0; m_db[m] = 0; m_db_prev[m] = 0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_step();
        end
    end

    function automatic logic [ND-1:0] exp_rst(input int m);
        logic [ND-1:0] r;
        for (int i = 0; i < ND; i++) r[i] = (cyc < m_t0[m] + HOLD + i * GAP);
        return r;
    endfunction

    task automatic cmp_inst(input int m, input logic [ND-1:0] r, input logic b, input logic d,
                            input logic c, input logic [7:0] n, input logic t);
        bit exp_done;
        exp_done = (cyc >= m_t0[m] + HOLD + (ND - 1) * GAP);
        check($sformatf("i%0d_rst_out", m), r, exp_rst(m));
        check($sformatf("i%0d_busy", m), b, !exp_done);
        check($sformatf("i%0d_done", m), d, exp_done);
        check($sformatf("i%0d_last_cause", m), c, m_cause[m]);
        check($sformatf("i%0d_reset_count", m), n, m_cnt[m]);
        check($sformatf("i%0d_tick", m), t, (cyc % TDIV) == TDIV - 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            cmp_inst(0, sif0.rst_out, sif0.busy, sif0.done, sif0.last_cause, sif0.reset_count, sif0.tick);
            cmp_inst(1, sif1.rst_out, sif1.busy, sif1.done, sif1.last_cause, sif1.reset_count, sif1.tick);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        bit found;
        int high, low;
        sif0.req = '0;
        sif1.req = '0;
        reset    = 1'b1;
        step(3);
        reset = 1'b0;

        $display("[TB] power-on release schedule");
        for (int k = 0; k <= 50; k++) begin
            case (k)
                0:  check("po_c0_rst", sif0.rst_out, 4'b1111);
                7:  check("po_c7_rst", sif0.rst_out, 4'b1111);
                8:  check("po_c8_rst", sif0.rst_out, 4'b1110);
                11: check("po_c11_rst", sif0.rst_out, 4'b1110);
                12: check("po_c12_rst", sif0.rst_out, 4'b1100);
                16: check("po_c16_rst", sif0.rst_out, 4'b1000);
                19: check("po_c19_done", sif0.done, 1'b0);
                20: begin
                    check("po_c20_rst", sif0.rst_out, 4'b0000);
                    check("po_c20_done", sif0.done, 1'b1);
                    check("po_c20_cause", sif0.last_cause, 1'b0);
                    check("po_c20_count", sif0.reset_count, 8'd0);
                end
                48: check("po_c48_tick", sif0.tick, 1'b0);
                49: check("po_c49_tick", sif0.tick, 1'b1);
                default: ;
            endcase
            if (k < 50) step(1);
        end

        $display("[TB] chord request latency");
        sif0.req = 3'b111;
        lat = 0;
        found = 1'b0;
        for (int j = 1; j <= 40 && !found; j++) begin
            step(1);
            if (sif0.rst_out == 4'b1111) begin
                found = 1'b1;
                lat = j;
            end
        end
        check("chord_latency", lat, 19);
        check("chord_count", sif0.reset_count, 8'd1);
        check("chord_cause", sif0.last_cause, 1'b1);
        sif0.req = '0;
        step(60);

        $display("[TB] partial chord and glitch rejection");
        sif0.req = 3'b011;
        step(100);
        check("partial_chord_count", sif0.reset_count, 8'd1);
        check("partial_chord_done", sif0.done, 1'b1);
        sif0.req = '0;
        step(5);
        sif0.req = 3'b111;
        step(15);
        sif0.req = '0;
        step(30);
        check("glitch15_count", sif0.reset_count, 8'd1);
        sif0.req = 3'b111;
        step(16);
        sif0.req = '0;
        step(60);
        check("pulse16_count", sif0.reset_count, 8'd2);

        $display("[TB] held button");
        sif0.req = 3'b111;
        step(200);
        check("held_busy", sif0.busy, 1'b1);
        check("held_rst", sif0.rst_out, 4'b1111);
        sif0.req = '0;
        step(25);
        check("held_c25_rst", sif0.rst_out, 4'b1111);
        step(1);
        check("held_c26_rst", sif0.rst_out, 4'b1110);
        step(30);

        $display("[TB] mid-release request (any mode)");
        sif1.req = 3'b010;
        step(30);
        sif1.req = '0;
        step(9);
        sif1.req = 3'b100;
        step(5);
        check("midrel_c14_rst", sif1.rst_out, 4'b1110);
        step(1);
        check("midrel_c15_rst", sif1.rst_out, 4'b1110);
        step(1);
        check("midrel_c16_rst", sif1.rst_out, 4'b1111);
        check("midrel_count", sif1.reset_count, 8'd2);

        $display("[TB] reset during release");
        sif1.req = '0;
        step(16);
        check("prereset_rst", sif1.rst_out, 4'b1110);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("postreset_count0", sif0.reset_count, 8'd0);
        check("postreset_count1", sif1.reset_count, 8'd0);
        check("postreset_cause1", sif1.last_cause, 1'b0);
        check("postreset_rst1", sif1.rst_out, 4'b1111);

        $display("[TB] randomized requests and count saturation");
        for (int it = 0; it < 400; it++) begin
            high = $urandom_range(3, 8);
            low  = $urandom_range(10, 30);
            sif0.req = NR'($urandom_range(0, 7));
            for (int h = 0; h < high; h++) begin
                sif1.req = NR'($urandom_range(1, 7));
                step(1);
            end
            sif1.req = '0;
            step(low);
        end
        check("saturated_count", sif1.reset_count, 8'd255);
        sif0.req = '0;
        step(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised power-on and manual reset generator for the FPGA top-level wrappers. It replaces the fixed 3-step startup reset and the single hard-wired button chord.
- Debounces a vector of manual reset requests, combined in chord (AND) or any (OR) mode.
- Holds all downstream reset domains asserted, then releases them one at a time in order.
- Reports sequencing status and a saturating count of manual resets, and emits a periodic tick strobe.

Parameters:
- NUM_DOMAINS, 4, number of reset outputs released in order (≥1).
- NUM_REQ, 3, width of manual request vector (≥1).
- REQ_MODE, 0, 0 = chord (all bits of req high), 1 = any bit of req high.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to change the debounced request (≥1).
- HOLD_CYCLES, 8, cycles all domains stay asserted before the first release (≥1).
- STAGE_GAP, 4, cycles between successive domain releases (≥1).
- TICK_DIV, 50, tick period in clk cycles (≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset (global/PLL-lock-loss).
- req  input  NUM_REQ  raw manual reset buttons, asynchronous to clk.
- rst_out  output  NUM_DOMAINS  per-domain active-high reset; bit 0 is released first.
- busy  output  1  high while in HOLD or RELEASE.
- done  output  1  high while in RUN (all domains released).
- last_cause  output  1  0 = last sequence caused by reset, 1 = caused by manual request.
- reset_count  output  8  saturating count of manual-request sequences (stops at 255).
- tick  output  1  one-cycle strobe every TICK_DIV cycles.

Behaviour:
- Reset (sampled at posedge clk while high):
  - state = HOLD, hold counter = 0, stage index = 0, gap counter = 0.
  - rst_out = all 1, busy = 1, done = 0, last_cause = 0, reset_count = 0.
  - Synchroniser flops = 0, debounced request = 0, debounce counter = 0, tick counter = 0, tick = 0.
  - Reset overrides every other event.
- Request path:
  - Each req bit passes through a 2-flop synchroniser.
  - The combined value (AND or OR per REQ_MODE) is debounced. req_db changes only after DEBOUNCE_CYCLES consecutive cycles of the combined value differing from req_db.
  - Any glitch restarts the debounce count.
- FSM states: HOLD, RELEASE, RUN.
  - HOLD: rst_out = all 1. The hold counter increments each cycle.
    - If req_db = 1, the hold counter is reloaded to 0 and the FSM stays in HOLD for as long as the button is held.
    - When the counter reaches HOLD_CYCLES−1 and req_db = 0, go to RELEASE with stage index = 0.
  - RELEASE: entering RELEASE clears rst_out[0] on that edge. Every STAGE_GAP cycles the stage index increments and the next bit clears.
    - Released bits stay 0. Unreleased bits stay 1.
    - After bit NUM_DOMAINS−1 clears, the state is RUN on that same edge.
  - RUN: rst_out = all 0, done = 1, busy = 0.
- Manual re-entry: a rising edge of req_db in RELEASE or RUN moves the FSM to HOLD on the next edge.
  - rst_out = all 1 from that edge.
  - last_cause = 1 and reset_count increments, saturating at 255.
  - A rising req_db already in HOLD does not increment the count.
- Cycle-level timing: let cycle 0 be the first cycle after reset deasserts, with no request.
  - rst_out[i] is 0 from cycle HOLD_CYCLES + i·STAGE_GAP.
  - done is 1 from cycle HOLD_CYCLES + (NUM_DOMAINS−1)·STAGE_GAP.
- Request latency: a clean req assertion reaches req_db 2 + DEBOUNCE_CYCLES cycles after the input change.
- NUM_DOMAINS = 1: RELEASE lasts zero cycles. HOLD goes directly to RUN, with rst_out[0] clearing on the transition edge.
- tick: free-running counter 0..TICK_DIV−1. tick = 1 in the cycle the counter equals TICK_DIV−1. It is unaffected by FSM state.
- All outputs are registered. There are no combinational paths from req to any output.

Decomposition:
- Package rst_seq_pkg:
  - state enum (HOLD, RELEASE, RUN).
  - REQ_MODE constants (MODE_CHORD = 0, MODE_ANY = 1).
  - Saturation limit constant (255).
- One sub-module, req_debounce: 2-flop sync per bit, mode combine, and debounce counter, producing req_db.
- The FSM, stage counters, status and tick logic remain in reset_sequencer.

Test Plan:
1. Power-on, defaults, no req: reset for 3 cycles, then low → rst_out = 4'b1111 for cycles 0–7; bit0 low at cycle 8, bit1 at 12, bit2 at 16, bit3 at 20; done = 1 from cycle 20; last_cause = 0; reset_count = 0.
2. Chord debounce, REQ_MODE = 0: in RUN, assert req = 3'b111 → rst_out = all 1 exactly 2+16+1 cycles later; reset_count = 1; last_cause = 1. req = 3'b011 held 100 cycles → no change.
3. Glitch rejection: in RUN, req = 3'b111 for 15 cycles then 0 → no reset. A 16-cycle stable pulse → sequence restarts.
4. Held button: hold req = 3'b111 for 200 cycles → rst_out stays all 1 and busy = 1 throughout. First release is 8 cycles after req_db falls.
5. Mid-release request: assert the debounced request when only rst_out[0] has cleared → all bits return to 1 next edge and the full 8+4·3 schedule restarts. Apply reset mid-RELEASE → reset_count returns to 0.
6. Saturation and tick, REQ_MODE = 1: 300 manual sequences → reset_count = 255. tick pulses every 50 cycles throughout, independent of FSM state.
